// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, sequencer/write-engine state types and init command table.
package lcd_pkg;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  typedef enum logic [2:0] {PWR_WAIT, INIT, LINE_ADDR, FETCH, CHAR_WR, FRAME_GAP} top_state_t;
  typedef enum logic [1:0] {WE_IDLE, WE_SETUP, WE_PULSE, WE_HOLD} we_state_t;
  function automatic logic [7:0] init_cmd(input logic [2:0] step);
    return step < 3'd2 ? CMD_FUNC_SET : step == 3'd2 ? CMD_DISP_ON : step == 3'd3 ? CMD_ENTRY : CMD_CLEAR;
  endfunction
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: one LCD bus write (SETUP, E PULSE, HOLD wait); done pulses the cycle after HOLD.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = 4,
  parameter int E_HIGH_CYC   = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       done
);
  localparam int CW = $clog2(max2(max2(SETUP_CYC, E_HIGH_CYC), max2(CMD_WAIT_CYC, CLR_WAIT_CYC)) + 1);
  we_state_t state, nxt;
  logic [CW-1:0] cnt, lim;
  logic long_r;
  always_comb begin
    lim = state == WE_SETUP ? CW'(SETUP_CYC - 1) : state == WE_PULSE ? CW'(E_HIGH_CYC - 1) :
          long_r ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
    nxt = state == WE_IDLE ? (start ? WE_SETUP : WE_IDLE) : cnt != lim ? state :
          state == WE_SETUP ? WE_PULSE : state == WE_PULSE ? WE_HOLD : WE_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= WE_IDLE;
    else state <= nxt;
  // RS/DATA stay latched after HOLD so the bus is stable until the next SETUP.
  always_ff @(posedge clk)
    if (rst) begin
      cnt      <= '0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
      long_r   <= 1'b0;
      done     <= 1'b0;
    end else begin
      cnt  <= (nxt != state || state == WE_IDLE) ? '0 : cnt + 1'b1;
      done <= state == WE_HOLD && cnt == lim;
      if (state == WE_IDLE && start) begin
        lcd_rs   <= rs;
        lcd_data <= data;
        long_r   <= long_wait;
      end
    end
  assign lcd_e = state == WE_PULSE;
endmodule

// File: rtl/lcd_char_driver.sv
// lcd_char_driver: HD44780 16x2 init + continuous refresh from a 32-entry character list.
// Define LCD_FRAME_GAP_EN to add an idle FRAME_GAP_CYC period after every frame.
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int PWRON_CYC    = 1000000,
  parameter int SETUP_CYC    = 4,
  parameter int E_HIGH_CYC   = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int FETCH_CYC    = 2
`ifdef LCD_FRAME_GAP_EN
  , parameter int FRAME_GAP_CYC = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);
`ifdef LCD_FRAME_GAP_EN
  localparam int   GAP    = FRAME_GAP_CYC;
  localparam logic GAP_EN = 1'b1;
`else
  localparam int   GAP    = 1;
  localparam logic GAP_EN = 1'b0;
`endif
  localparam int CW = $clog2(max2(max2(PWRON_CYC, FETCH_CYC), GAP) + 1);
  top_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] step;
  logic [7:0] char_r, wr_data;
  logic issued, start, wr_rs, done, eng_rs;
  always_comb begin
    nxt     = state;
    start   = 1'b0;
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    case (state)
      PWR_WAIT: nxt = cnt == CW'(PWRON_CYC - 1) ? INIT : PWR_WAIT;
      INIT: begin
        wr_data = init_cmd(step);
        start   = !issued;
        nxt     = done && step == 3'd4 ? LINE_ADDR : INIT;
      end
      LINE_ADDR: begin
        wr_data = index[4] ? CMD_LINE2 : CMD_LINE1;
        start   = !issued;
        nxt     = done ? FETCH : LINE_ADDR;
      end
      FETCH: nxt = cnt == CW'(FETCH_CYC - 1) ? CHAR_WR : FETCH;
      CHAR_WR: begin
        wr_rs   = 1'b1;
        wr_data = char_r;
        start   = !issued;
        nxt     = !done ? CHAR_WR : index[3:0] != 4'hF ? FETCH : (GAP_EN && index[4]) ? FRAME_GAP : LINE_ADDR;
      end
      FRAME_GAP: nxt = cnt == CW'(GAP - 1) ? LINE_ADDR : FRAME_GAP;
      default: nxt = PWR_WAIT;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= PWR_WAIT;
    else state <= nxt;
  // issued blocks re-starting the engine until its done pulse for the current write.
  always_ff @(posedge clk)
    if (rst) begin
      cnt        <= '0;
      step       <= '0;
      char_r     <= '0;
      issued     <= 1'b0;
      index      <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= (nxt == state && (state == PWR_WAIT || state == FETCH || state == FRAME_GAP)) ? cnt + 1'b1 : '0;
      issued     <= done ? 1'b0 : issued | start;
      frame_done <= state == CHAR_WR && done && index == 5'd31;
      if (state == INIT && done) step <= step + 1'b1;
      if (state == INIT && done && step == 3'd4) init_done <= 1'b1;
      if (state == FETCH && nxt == CHAR_WR) char_r <= char_in;
      if (state == CHAR_WR && done) index <= index + 1'b1;
    end
  lcd_write_engine #(
    .SETUP_CYC   (SETUP_CYC),
    .E_HIGH_CYC  (E_HIGH_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_eng (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rs       (wr_rs),
    .data     (wr_data),
    .long_wait(!wr_rs && wr_data == CMD_CLEAR),
    .lcd_rs   (eng_rs),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .done     (done)
  );
  assign lcd_rs = eng_rs && state != FRAME_GAP;
  assign lcd_rw = 1'b0;
endmodule

// File: tb/tb_lcd_char_driver.sv
// tb_lcd_char_driver: directed checks of init, refresh frame, data capture, frame gap and mid-run reset.
module tb_lcd_char_driver;
`ifdef LCD_FRAME_GAP_EN
  localparam int GAP_EXP = 30;
`else
  localparam int GAP_EXP = 0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic [4:0] index;
  logic lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic [7:0] lcd_data;
  int checks = 0, failures = 0, cyc = 0, cnt5 = 0, r0 = 0;
  lcd_char_driver #(
    .PWRON_CYC(10), .SETUP_CYC(2), .E_HIGH_CYC(3), .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(20), .FETCH_CYC(2)
`ifdef LCD_FRAME_GAP_EN
    , .FRAME_GAP_CYC(30)
`endif
  ) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .index(index), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_data(lcd_data), .init_done(init_done), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Registered character source; index 5 is corrupted to 0x7A three cycles after its fetch ends.
  always @(posedge clk) begin
    cnt5    <= index == 5'd5 ? cnt5 + 1 : 0;
    char_in <= (index == 5'd5 && cnt5 >= 4) ? 8'h7A : 8'h40 + {3'b000, index};
  end
  logic e_d = 1'b0, e_d2 = 1'b0, rs_d = 1'b0, rs_d2 = 1'b0, fd_prev = 1'b0, saw_7a = 1'b0;
  logic [7:0] d_d = 8'h00, d_d2 = 8'h00;
  logic [4:0] fd_idx = 5'd0;
  int hi = 0, n_ev = 0, fd_n = 0, fd_hi = 0, fd_cyc = 0, fd_ev = 0;
  logic ev_rs[512], ev_setup[512], ev_stab[512], ev_init[512];
  logic [7:0] ev_data[512];
  int ev_cyc[512], ev_hi[512];
  logic [7:0] init_exp[5] = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
  always @(negedge clk) begin
    e_d <= lcd_e; e_d2 <= e_d; rs_d <= lcd_rs; rs_d2 <= rs_d; d_d <= lcd_data; d_d2 <= d_d;
    if (lcd_e) hi <= e_d ? hi + 1 : 1;
    if (lcd_e && !e_d) begin
      ev_rs[n_ev]    <= lcd_rs;
      ev_data[n_ev]  <= lcd_data;
      ev_cyc[n_ev]   <= cyc;
      ev_init[n_ev]  <= init_done;
      ev_setup[n_ev] <= !e_d2 && rs_d == lcd_rs && rs_d2 == lcd_rs && d_d == lcd_data && d_d2 == lcd_data;
    end
    if (!lcd_e && e_d) begin
      ev_hi[n_ev]   <= hi;
      ev_stab[n_ev] <= rs_d == ev_rs[n_ev] && d_d == ev_data[n_ev];
      n_ev          <= n_ev + 1;
    end
    if (frame_done) begin
      fd_hi <= fd_hi + 1;
      if (!fd_prev) begin
        fd_n <= fd_n + 1; fd_cyc <= cyc; fd_ev <= n_ev; fd_idx <= index;
      end
    end
    fd_prev <= frame_done;
    if (char_in == 8'h7A) saw_7a <= 1'b1;
  end
  task automatic wait_ev(input int n, input int budget, input string name);
    int k = 0;
    while (n_ev < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (n_ev < n) begin
      failures++;
      $display("FAIL %s timeout: strobes=%0d required=%0d", name, n_ev, n);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_data, index, init_done, frame_done} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got e=%b rs=%b rw=%b data=%h index=%0d init=%b frame=%b required all 0",
               lcd_e, lcd_rs, lcd_rw, lcd_data, index, init_done, frame_done);
    end
    rst = 1'b0;
    r0 = cyc;
  endtask
  task automatic test_init(input int base, input int r);
    wait_ev(base + 6, 600, "init_strobes");
    checks++;
    if (ev_cyc[base] - r !== 13) begin
      failures++;
      $display("FAIL pwron_delay: first E rise %0d cycles after reset, required 13", ev_cyc[base] - r);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ev_data[base+i] !== init_exp[i] || ev_rs[base+i] !== 1'b0) begin
        failures++;
        $display("FAIL init_cmd%0d: got rs=%b data=%h required rs=0 data=%h", i, ev_rs[base+i], ev_data[base+i], init_exp[i]);
      end
      checks++;
      if (ev_hi[base+i] !== 3 || ev_setup[base+i] !== 1'b1 || ev_stab[base+i] !== 1'b1) begin
        failures++;
        $display("FAIL init_strobe%0d: got e_high=%0d setup_ok=%b stable=%b required 3 1 1", i, ev_hi[base+i], ev_setup[base+i], ev_stab[base+i]);
      end
      checks++;
      if (ev_init[base+i] !== 1'b0) begin
        failures++;
        $display("FAIL init_done_early%0d: got %b required 0", i, ev_init[base+i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (ev_cyc[base+i] - ev_cyc[base+i-1] !== 12) begin
        failures++;
        $display("FAIL cmd_spacing%0d: got %0d required 12", i, ev_cyc[base+i] - ev_cyc[base+i-1]);
      end
    end
    checks++;
    if (ev_cyc[base+5] - ev_cyc[base+4] !== 27 || ev_data[base+5] !== 8'h80 || ev_rs[base+5] !== 1'b0) begin
      failures++;
      $display("FAIL clear_wait: got spacing=%0d data=%h rs=%b required 27 80 0", ev_cyc[base+5] - ev_cyc[base+4], ev_data[base+5], ev_rs[base+5]);
    end
    checks++;
    if (ev_init[base+5] !== 1'b1) begin
      failures++;
      $display("FAIL init_done_set: got %b required 1", ev_init[base+5]);
    end
  endtask
  task automatic test_frame(input int base);
    int k = 0;
    logic [7:0] ed;
    logic er;
    while (fd_n < 1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (fd_n < 1) begin
      failures++;
      $display("FAIL frame_done_timeout: got %0d pulses required 1", fd_n);
    end
    for (int j = 0; j < 34; j++) begin
      ed = j == 0 ? 8'h80 : j < 17 ? 8'h40 + 8'(j - 1) : j == 17 ? 8'hC0 : 8'h50 + 8'(j - 18);
      er = !(j == 0 || j == 17);
      checks++;
      if (ev_data[base+j] !== ed || ev_rs[base+j] !== er) begin
        failures++;
        $display("FAIL frame_write%0d: got rs=%b data=%h required rs=%b data=%h", j, ev_rs[base+j], ev_data[base+j], er, ed);
      end
      checks++;
      if (ev_hi[base+j] !== 3 || ev_setup[base+j] !== 1'b1 || ev_stab[base+j] !== 1'b1) begin
        failures++;
        $display("FAIL frame_strobe%0d: got e_high=%0d setup_ok=%b stable=%b required 3 1 1", j, ev_hi[base+j], ev_setup[base+j], ev_stab[base+j]);
      end
    end
    checks++;
    if (fd_idx !== 5'd0 || fd_ev !== base + 34) begin
      failures++;
      $display("FAIL frame_wrap: got index=%0d strobes=%0d required index=0 strobes=%0d", fd_idx, fd_ev - base, 34);
    end
  endtask
  task automatic test_char_hold(input int base);
    checks++;
    if (saw_7a !== 1'b1) begin
      failures++;
      $display("FAIL stub_change: got %b required 1", saw_7a);
    end
    checks++;
    if (ev_data[base+6] !== 8'h45) begin
      failures++;
      $display("FAIL char_capture: got %h required 45", ev_data[base+6]);
    end
  endtask
  task automatic test_frame_gap;
    wait_ev(fd_ev + 1, 300, "gap_line1");
    checks++;
    if (ev_cyc[fd_ev] - fd_cyc - 3 !== GAP_EXP || ev_data[fd_ev] !== 8'h80) begin
      failures++;
      $display("FAIL frame_gap: got idle=%0d data=%h required idle=%0d data=80", ev_cyc[fd_ev] - fd_cyc - 3, ev_data[fd_ev], GAP_EXP);
    end
    checks++;
    if (fd_hi !== 1 || fd_n !== 1) begin
      failures++;
      $display("FAIL frame_done_pulse: got high_cycles=%0d pulses=%0d required 1 1", fd_hi, fd_n);
    end
  endtask
  task automatic test_reset_mid;
    int k = 0;
    int r, base;
    while (!(lcd_e === 1'b1 && lcd_rs === 1'b1 && index === 5'd20) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 3000) begin
      failures++;
      $display("FAIL char20_timeout: got index=%0d required 20", index);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (lcd_e !== 1'b0 || index !== 5'd0 || init_done !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got e=%b index=%0d init=%b frame=%b required 0 0 0 0", lcd_e, index, init_done, frame_done);
    end
    rst = 1'b0;
    r = cyc;
    @(negedge clk);
    base = n_ev;
    test_init(base, r);
  endtask
  initial begin
    test_reset;
    test_init(0, r0);
    test_frame(5);
    test_char_hold(5);
    test_frame_gap;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
